// File: rtl/fetch_unit.sv
// Instruction fetch stage: one ICache request in flight, predictor lookup on
// each returned word, results queued in order for the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned IQ_DEPTH_LOG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_instr,
  output logic        pred_query_valid,
  output logic [31:0] pred_instr,
  output logic [31:0] pred_cur_pc,
  input  logic [31:0] pred_next_pc,
  input  logic        pred_taken,
  output logic        iq_out_valid,
  input  logic        iq_out_ready,
  output logic [31:0] iq_out_instr,
  output logic [31:0] iq_out_pc,
  output logic        iq_out_pred_taken,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc
);

  localparam int unsigned PTR_W = IQ_DEPTH_LOG;
  localparam int unsigned CNT_W = IQ_DEPTH_LOG + 1;
  localparam int unsigned DEPTH = 1 << IQ_DEPTH_LOG;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_mem_instr [DEPTH];
  logic [31:0]        r_mem_pc    [DEPTH];
  logic               r_mem_taken [DEPTH];

  logic               w_space;
  logic               w_accept;
  logic               w_pop;

  // Handshake qualifiers; a flush suppresses both push and pop.
  assign w_space  = (r_count < CNT_W'(DEPTH));
  assign w_accept = !rst && rdy && (r_state == S_WAIT) && ic_resp_valid && !rob_flush;
  assign w_pop    = rdy && !rob_flush && (r_count != '0) && iq_out_ready;

  // State register; rdy low freezes the fetch sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: request when there is room, wait for the word, or drop a
  // word whose request was made before a flush.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!rob_flush && w_space) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rob_flush) begin
          w_state_nxt = ic_resp_valid ? S_IDLE : S_DISCARD;
        end else if (ic_resp_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (ic_resp_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch PC: redirect on flush, follow the predictor on an accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (rdy) begin
      if (rob_flush) begin
        r_pc <= rob_flush_pc;
      end else if (w_accept) begin
        r_pc <= pred_next_pc;
      end
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (rob_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_accept) r_tail <= r_tail + PTR_W'(1);
        if (w_pop)    r_head <= r_head + PTR_W'(1);
        case ({w_accept, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Queue storage write; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_instr[r_tail] <= ic_resp_instr;
      r_mem_pc[r_tail]    <= r_pc;
      r_mem_taken[r_tail] <= pred_taken;
    end
  end

  assign ic_req_valid      = (r_state == S_WAIT);
  assign ic_req_addr       = r_pc;
  assign pred_query_valid  = w_accept;
  assign pred_instr        = ic_resp_instr;
  assign pred_cur_pc       = r_pc;
  assign iq_out_valid      = (r_count != '0);
  assign iq_out_instr      = r_mem_instr[r_head];
  assign iq_out_pc         = r_mem_pc[r_head];
  assign iq_out_pred_taken = r_mem_taken[r_head];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for the
// full-queue, flush and freeze cases, then randomized traffic against a
// queue-based reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_instr;
  logic        pred_query_valid;
  logic [31:0] pred_instr;
  logic [31:0] pred_cur_pc;
  logic [31:0] pred_next_pc;
  logic        pred_taken;
  logic        iq_out_valid;
  logic        iq_out_ready;
  logic [31:0] iq_out_instr;
  logic [31:0] iq_out_pc;
  logic        iq_out_pred_taken;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;

  fetch_unit #(.RESET_PC(32'h0), .IQ_DEPTH_LOG(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_instr(ic_resp_instr),
    .pred_query_valid(pred_query_valid), .pred_instr(pred_instr),
    .pred_cur_pc(pred_cur_pc), .pred_next_pc(pred_next_pc), .pred_taken(pred_taken),
    .iq_out_valid(iq_out_valid), .iq_out_ready(iq_out_ready),
    .iq_out_instr(iq_out_instr), .iq_out_pc(iq_out_pc),
    .iq_out_pred_taken(iq_out_pred_taken),
    .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch queue contents, fetch PC, request outstanding
  // and visible, response owed but to be dropped.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        tk;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_req = 1'b0;
  bit          m_drop = 1'b0;

  // Directed vector record: per-cycle inputs and expected outputs.
  typedef struct {
    logic        rsp;
    logic [31:0] nxt;
    logic        tk;
    logic        iqr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iqv;
    logic        e_q;
    logic [31:0] e_hpc;
    logic        e_htk;
  } vec_t;
  vec_t tbl[17];
  vec_t cur;
  bit   vec_on = 1'b0;
  int   vec_idx = 0;

  function automatic vec_t mk(input logic rsp, input logic [31:0] nxt, input logic tk,
                              input logic iqr, input logic e_req, input logic [31:0] e_addr,
                              input logic e_iqv, input logic e_q, input logic [31:0] e_hpc,
                              input logic e_htk);
    vec_t v;
    v.rsp = rsp; v.nxt = nxt; v.tk = tk; v.iqr = iqr; v.e_req = e_req;
    v.e_addr = e_addr; v.e_iqv = e_iqv; v.e_q = e_q; v.e_hpc = e_hpc; v.e_htk = e_htk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    bit   exp_q;
    int   sz;
    bit   pop;
    ent_t e;
    @(negedge clk);
    if (!rst) begin
      exp_q = rdy && m_req && ic_resp_valid && !rob_flush;
      chk1("req_valid", ic_req_valid, m_req);
      if (m_req) chk("req_addr", ic_req_addr, m_pc);
      chk1("iq_valid", iq_out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("head_instr", iq_out_instr, mq[0].instr);
        chk("head_pc", iq_out_pc, mq[0].pc);
        chk1("head_taken", iq_out_pred_taken, mq[0].tk);
      end
      chk1("query_valid", pred_query_valid, exp_q);
      if (exp_q) begin
        chk("query_pc", pred_cur_pc, m_pc);
        chk("query_instr", pred_instr, ic_resp_instr);
      end
      if (vec_on) begin
        chk1($sformatf("vec%0d_req_valid", vec_idx), ic_req_valid, cur.e_req);
        if (cur.e_req) chk($sformatf("vec%0d_req_addr", vec_idx), ic_req_addr, cur.e_addr);
        chk1($sformatf("vec%0d_iq_valid", vec_idx), iq_out_valid, cur.e_iqv);
        chk1($sformatf("vec%0d_query", vec_idx), pred_query_valid, cur.e_q);
        if (cur.e_iqv) begin
          chk($sformatf("vec%0d_head_pc", vec_idx), iq_out_pc, cur.e_hpc);
          chk1($sformatf("vec%0d_head_taken", vec_idx), iq_out_pred_taken, cur.e_htk);
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_pc = 32'h0; m_req = 1'b0; m_drop = 1'b0;
    end else if (rdy) begin
      sz  = mq.size();
      pop = (sz > 0) && iq_out_ready && !rob_flush;
      if (rob_flush) begin
        mq.delete();
        if (m_req || m_drop) m_drop = !ic_resp_valid;
        m_req = 1'b0;
        m_pc  = rob_flush_pc;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_req) begin
          if (ic_resp_valid) begin
            e.instr = ic_resp_instr; e.pc = m_pc; e.tk = pred_taken;
            mq.push_back(e);
            m_pc  = pred_next_pc;
            m_req = 1'b0;
          end
        end else if (m_drop) begin
          if (ic_resp_valid) m_drop = 1'b0;
        end else if (sz < 16) begin
          m_req = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; ic_resp_valid = 1'b0; rob_flush = 1'b0;
    iq_out_ready = 1'b0; ic_resp_instr = 32'h0; pred_next_pc = 32'h0;
    pred_taken = 1'b0; rob_flush_pc = 32'h0;
    repeat (2) cyc();
    rst = 1'b0;
    chk1("rst_req_valid", ic_req_valid, 1'b0);
    chk1("rst_iq_valid", iq_out_valid, 1'b0);
    chk1("rst_query", pred_query_valid, 1'b0);
  endtask

  task automatic wait_req();
    int g = 0;
    while (!ic_req_valid && g < 40) begin
      cyc();
      g++;
    end
    chk1("req_timeout", ic_req_valid, 1'b1);
  endtask

  task automatic fetch_one(input int lat, input logic [31:0] nxt, input logic tk);
    wait_req();
    repeat (lat) cyc();
    ic_resp_valid = 1'b1; ic_resp_instr = $urandom; pred_next_pc = nxt; pred_taken = tk;
    cyc();
    ic_resp_valid = 1'b0;
  endtask

  initial begin
    bit busy;
    rst = 1'b1; rdy = 1'b1; ic_resp_valid = 1'b0; ic_resp_instr = 32'h0;
    pred_next_pc = 32'h0; pred_taken = 1'b0; iq_out_ready = 1'b0;
    rob_flush = 1'b0; rob_flush_pc = 32'h0;

    //            rsp nxt          tk   iqr  req  addr         iqv  q    hpc          htk
    tbl[0]  = mk(0, 32'h0,       0, 0, 0, 32'h0,       0, 0, 32'h0,       0);
    tbl[1]  = mk(0, 32'h0,       0, 0, 1, 32'h0,       0, 0, 32'h0,       0);
    tbl[2]  = mk(1, 32'h4,       0, 0, 1, 32'h0,       0, 1, 32'h0,       0);
    tbl[3]  = mk(0, 32'h0,       0, 0, 0, 32'h0,       1, 0, 32'h0,       0);
    tbl[4]  = mk(0, 32'h0,       0, 0, 1, 32'h4,       1, 0, 32'h0,       0);
    tbl[5]  = mk(1, 32'h8,       0, 0, 1, 32'h4,       1, 1, 32'h0,       0);
    tbl[6]  = mk(0, 32'h0,       0, 0, 0, 32'h0,       1, 0, 32'h0,       0);
    tbl[7]  = mk(0, 32'h0,       0, 0, 1, 32'h8,       1, 0, 32'h0,       0);
    tbl[8]  = mk(1, 32'h100,     1, 0, 1, 32'h8,       1, 1, 32'h0,       0);
    tbl[9]  = mk(0, 32'h0,       0, 0, 0, 32'h0,       1, 0, 32'h0,       0);
    tbl[10] = mk(0, 32'h0,       0, 0, 1, 32'h100,     1, 0, 32'h0,       0);
    tbl[11] = mk(1, 32'h104,     0, 0, 1, 32'h100,     1, 1, 32'h0,       0);
    tbl[12] = mk(0, 32'h0,       0, 1, 0, 32'h0,       1, 0, 32'h0,       0);
    tbl[13] = mk(0, 32'h0,       0, 1, 1, 32'h104,     1, 0, 32'h4,       0);
    tbl[14] = mk(0, 32'h0,       0, 1, 1, 32'h104,     1, 0, 32'h8,       1);
    tbl[15] = mk(0, 32'h0,       0, 1, 1, 32'h104,     1, 0, 32'h100,     0);
    tbl[16] = mk(0, 32'h0,       0, 0, 1, 32'h104,     0, 0, 32'h0,       0);

    // Sequential fetch, predicted-taken redirect, then draining the queue.
    do_reset();
    vec_on = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cur = tbl[i];
      vec_idx = i;
      ic_resp_valid = cur.rsp;
      ic_resp_instr = 32'h00100093 + (32'(i) << 20);
      pred_next_pc  = cur.nxt;
      pred_taken    = cur.tk;
      iq_out_ready  = cur.iqr;
      cyc();
    end
    vec_on = 1'b0;
    ic_resp_valid = 1'b0; iq_out_ready = 1'b0;

    // Fill the queue, confirm fetch stalls, one pop admits exactly one fetch.
    do_reset();
    for (int i = 0; i < 16; i++) fetch_one(1, m_pc + 32'h4, 1'b0);
    repeat (4) begin
      cyc();
      chk1("full_no_req", ic_req_valid, 1'b0);
    end
    iq_out_ready = 1'b1;
    cyc();
    iq_out_ready = 1'b0;
    fetch_one(0, m_pc + 32'h4, 1'b1);
    repeat (5) begin
      cyc();
      chk1("refill_no_req", ic_req_valid, 1'b0);
    end
    iq_out_ready = 1'b1;
    repeat (16) cyc();
    iq_out_ready = 1'b0;
    chk1("drained_iq_valid", iq_out_valid, 1'b0);

    // Flush while waiting; the late response must be dropped.
    do_reset();
    fetch_one(0, 32'h4, 1'b0);
    fetch_one(1, 32'h8, 1'b0);
    wait_req();
    rob_flush = 1'b1; rob_flush_pc = 32'h200;
    cyc();
    rob_flush = 1'b0;
    chk1("flush_iq_empty", iq_out_valid, 1'b0);
    chk1("flush_req_low", ic_req_valid, 1'b0);
    repeat (2) cyc();
    ic_resp_valid = 1'b1; ic_resp_instr = 32'hDEADBEEF; pred_next_pc = 32'h999;
    cyc();
    ic_resp_valid = 1'b0;
    chk1("discard_iq_empty", iq_out_valid, 1'b0);
    wait_req();
    chk("flush_redirect_addr", ic_req_addr, 32'h200);

    // Flush coinciding with a response and a decoder pop.
    do_reset();
    fetch_one(0, 32'h4, 1'b0);
    fetch_one(0, 32'h8, 1'b0);
    wait_req();
    ic_resp_valid = 1'b1; ic_resp_instr = 32'h00100093; pred_next_pc = 32'h77;
    iq_out_ready = 1'b1; rob_flush = 1'b1; rob_flush_pc = 32'h300;
    cyc();
    ic_resp_valid = 1'b0; iq_out_ready = 1'b0; rob_flush = 1'b0;
    chk1("flush_resp_iq_empty", iq_out_valid, 1'b0);
    wait_req();
    chk("flush_resp_addr", ic_req_addr, 32'h300);

    // Freeze for five cycles mid-request; nothing may move.
    do_reset();
    fetch_one(0, 32'h20, 1'b0);
    fetch_one(0, 32'h40, 1'b0);
    wait_req();
    rdy = 1'b0; iq_out_ready = 1'b1;
    repeat (5) begin
      cyc();
      chk("frz_addr", ic_req_addr, 32'h40);
      chk1("frz_req", ic_req_valid, 1'b1);
      chk("frz_head_pc", iq_out_pc, 32'h0);
    end
    rdy = 1'b1; iq_out_ready = 1'b0;
    fetch_one(0, 32'h44, 1'b0);
    wait_req();
    chk("resume_addr", ic_req_addr, 32'h44);

    // Randomized traffic with a simple ICache responder.
    do_reset();
    busy = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (ic_req_valid) busy = 1'b1;
      rdy           = ($urandom % 10) != 0;
      iq_out_ready  = ($urandom % 2) != 0;
      rob_flush     = ($urandom % 32) == 0;
      rob_flush_pc  = $urandom;
      pred_next_pc  = $urandom;
      pred_taken    = ($urandom % 2) != 0;
      ic_resp_instr = $urandom;
      if (rdy) ic_resp_valid = busy && (($urandom % 3) == 0);
      else     ic_resp_valid = ($urandom % 4) == 0;
      cyc();
      if (rdy && ic_resp_valid) busy = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage: holds the architectural fetch PC, requests instruction words from the ICache, and consults the branch predictor for each returned word.
- Each returned word is pushed, with its PC and predicted-taken bit, into an in-order instruction queue drained by the decoder.
- On a ROB flush, all fetched state is discarded and fetch restarts at the redirect PC.

Parameters:
- RESET_PC, 32'h0, fetch PC after reset.
- IQ_DEPTH_LOG, 4, log2 of instruction-queue depth (16 entries).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low = freeze all state
- ic_req_valid  out  1  fetch request, level-held until response
- ic_req_addr  out  32  fetch address, stable while ic_req_valid
- ic_resp_valid  in  1  one-cycle pulse, instruction word valid
- ic_resp_instr  in  32  returned instruction word
- pred_query_valid  out  1  predictor lookup strobe (= accepted ic_resp_valid)
- pred_instr  out  32  word under lookup (= ic_resp_instr)
- pred_cur_pc  out  32  PC of that word (= ic_req_addr)
- pred_next_pc  in  32  predicted next PC, combinational, same cycle as query
- pred_taken  in  1  predicted taken, combinational, same cycle as query
- iq_out_valid  out  1  queue non-empty
- iq_out_ready  in  1  decoder accepts head
- iq_out_instr  out  32  head instruction
- iq_out_pc  out  32  head PC
- iq_out_pred_taken  out  1  head prediction bit
- rob_flush  in  1  mispredict redirect pulse
- rob_flush_pc  in  32  redirect target

Behaviour:
- Reset (rst=1 at posedge, dominates rdy and flush):
  - pc=RESET_PC, state=IDLE, queue empty (head=tail=count=0).
  - ic_req_valid=0, iq_out_valid=0, pred_query_valid=0.
- rdy=0: no state change; outputs hold; an ic_resp_valid arriving while rdy=0 is not captured (the ICache shares rdy).
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if count+pending < 2^IQ_DEPTH_LOG (pending is always 0 here), go to WAIT next cycle.
  - WAIT: ic_req_valid=1, ic_req_addr=pc.
    - On ic_resp_valid:
      - push {ic_resp_instr, pc, pred_taken} at tail;
      - pc <= pred_next_pc;
      - go to IDLE.
    - One instruction in flight maximum; minimum fetch cadence is 2 cycles per instruction.
  - DISCARD: ic_req_valid=0. Wait for ic_resp_valid, drop the word (no push, no predictor query), then go to IDLE.
- Space check: a request is issued only when count < depth, so a push can never overflow. A push and pop in the same cycle leave count unchanged.
- Queue pop: when iq_out_valid && iq_out_ready, head advances and count decrements. Head fields are registered array reads, valid whenever iq_out_valid=1.
- Pointer arithmetic: head and tail are IQ_DEPTH_LOG bits and wrap modulo depth; count is IQ_DEPTH_LOG+1 bits.
- Flush (rob_flush=1, rdy=1):
  - queue cleared, pc <= rob_flush_pc; any push or pop in the same cycle is suppressed.
  - from WAIT without ic_resp_valid in the same cycle -> DISCARD.
  - from WAIT with ic_resp_valid in the same cycle -> response dropped, go to IDLE.
  - from IDLE or DISCARD -> IDLE, or stay in DISCARD if its response is still outstanding.
- Predictor contract: pred_query_valid=1 only in the WAIT-accept cycle; pred_next_pc and pred_taken are sampled that same cycle.
- Address arithmetic is 32-bit modulo; no alignment checking is done here.

Test Plan:
- Reset, then ICache answers each request after 2 cycles with addi words, predictor returns pc+4 / not-taken -> ic_req_addr sequence 0x0, 0x4, 0x8; queue holds 3 entries with PCs 0x0, 0x4, 0x8 and pred_taken=0.
- Predictor returns pred_next_pc=0x100, taken=1 for the word at 0x8 -> next ic_req_addr=0x100; entry at 0x8 has iq_out_pred_taken=1.
- iq_out_ready=0 while 16 words arrive -> count=16, ic_req_valid stays 0; one pop -> exactly one new request issued; tail wraps to 0 correctly.
- rob_flush with rob_flush_pc=0x200 while in WAIT, response arrives 3 cycles later -> that word is not queued, iq_out_valid=0 right after the flush, next ic_req_addr=0x200.
- rob_flush in the same cycle as ic_resp_valid and a decoder pop -> queue empty, no push, next request at the flush PC.
- rdy=0 for 5 cycles mid-WAIT, with ic_resp_valid held low -> ic_req_addr, count and queue contents unchanged; normal progress resumes when rdy=1.
